// File: rtl/writeback_if.sv
// MEM/WB boundary bundle: memory-stage outputs and pipeline control into
// the writeback stage, and register-file write port / forwarding signals out.
interface writeback_if #(
    parameter int WIDTH = 32
);
    // No valid/ready pair here. Every cycle carries an instruction or a bubble.
    // stallW=1 holds the stage, and flushW=1 (which wins over stallW) captures a bubble.
    logic             stallW;
    logic             flushW;
    logic             jumpM;
    logic             RegWriteM;
    logic [2:0]       MemtoRegM;
    logic [4:0]       WriteRegM;
    logic [WIDTH-1:0] ALUMultOutM;
    logic [WIDTH-1:0] PCPlus8M;
    logic [WIDTH-1:0] ReadDataM;

    logic             jumpW;
    logic             RegWriteW;
    logic [4:0]       WriteRegW;
    logic [WIDTH-1:0] ResultW;
    logic             MisalignW;
    logic [WIDTH-1:0] RetireCountW;

    modport master (
        output stallW, flushW, jumpM, RegWriteM, MemtoRegM, WriteRegM,
               ALUMultOutM, PCPlus8M, ReadDataM,
        input  jumpW, RegWriteW, WriteRegW, ResultW, MisalignW, RetireCountW
    );

    modport slave (
        input  stallW, flushW, jumpM, RegWriteM, MemtoRegM, WriteRegM,
               ALUMultOutM, PCPlus8M, ReadDataM,
        output jumpW, RegWriteW, WriteRegW, ResultW, MisalignW, RetireCountW
    );
endinterface

// File: rtl/writeback.sv
// MIPS writeback stage: registers the memory-stage result, extracts sub-word
// loads, flags misaligned loads and counts committed register writes.
module writeback #(
    parameter int WIDTH      = 32,
    parameter int BIG_ENDIAN = 1
) (
    input logic        clk,
    input logic        rst,
    writeback_if.slave wb
);
    logic [1:0]       a;
    logic [1:0]       byte_lane;
    logic             half_lane;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;
    logic [WIDTH-1:0] sel;
    logic             mis;
    logic             we_next;

    logic             jump_q;
    logic             regwrite_q;
    logic [4:0]       writereg_q;
    logic [WIDTH-1:0] result_q;
    logic             misalign_q;
    logic [WIDTH-1:0] retire_cnt;

    assign a = wb.ALUMultOutM[1:0];

    // Lane index counted from bit 0; big-endian offset 0 is the top lane.
    assign byte_lane = (BIG_ENDIAN != 0) ? ~a : a;
    assign half_lane = (BIG_ENDIAN != 0) ? ~a[1] : a[1];
    assign byte_val  = wb.ReadDataM[{byte_lane, 3'b000} +: 8];
    assign half_val  = wb.ReadDataM[{half_lane, 4'b0000} +: 16];

    always_comb begin
        sel = wb.ALUMultOutM;
        mis = 1'b0;
        case (wb.MemtoRegM)
            3'b000: sel = wb.ALUMultOutM;
            3'b001: begin
                sel = wb.ReadDataM;
                mis = (a != 2'b00);
            end
            3'b010: sel = {{(WIDTH-8){byte_val[7]}}, byte_val};
            3'b011: sel = {{(WIDTH-8){1'b0}}, byte_val};
            3'b100: begin
                sel = {{(WIDTH-16){half_val[15]}}, half_val};
                mis = a[0];
            end
            3'b101: begin
                sel = {{(WIDTH-16){1'b0}}, half_val};
                mis = a[0];
            end
            3'b110: sel = wb.PCPlus8M;
            default: sel = wb.ALUMultOutM;
        endcase
    end

    assign we_next = wb.RegWriteM & (wb.WriteRegM != 5'd0) & ~mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            jump_q     <= 1'b0;
            regwrite_q <= 1'b0;
            writereg_q <= 5'd0;
            result_q   <= '0;
            misalign_q <= 1'b0;
            retire_cnt <= '0;
        end else if (wb.flushW) begin
            jump_q     <= 1'b0;
            regwrite_q <= 1'b0;
            writereg_q <= 5'd0;
            result_q   <= '0;
            misalign_q <= 1'b0;
        end else if (!wb.stallW) begin
            jump_q     <= wb.jumpM;
            regwrite_q <= we_next;
            writereg_q <= wb.WriteRegM;
            result_q   <= sel;
            misalign_q <= mis;
            if (we_next) retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign wb.jumpW        = jump_q;
    assign wb.RegWriteW    = regwrite_q;
    assign wb.WriteRegW    = writereg_q;
    assign wb.ResultW      = result_q;
    assign wb.MisalignW    = misalign_q;
    assign wb.RetireCountW = retire_cnt;
endmodule

// File: tb/tb_writeback.sv
// Bench for the writeback stage: a reference model pushes expected outputs
// per driven cycle; each scenario task pops and compares after the edge.
module tb_writeback;
  logic clk;
  logic rst;

  writeback_if #(.WIDTH(32)) wb_bus ();

  writeback #(.WIDTH(32), .BIG_ENDIAN(1)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: {jumpW, RegWriteW, WriteRegW, ResultW, MisalignW, RetireCountW}
  logic [71:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic        m_jump, m_rw, m_mis;
  logic [4:0]  m_wreg;
  logic [31:0] m_res, m_cnt;

  function automatic logic [31:0] model_sel(input logic [2:0] op, input logic [31:0] alu,
                                            input logic [31:0] pc8, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (alu[1:0])
      2'd0: b = rd[31:24];
      2'd1: b = rd[23:16];
      2'd2: b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = alu[1] ? rd[15:0] : rd[31:16];
    case (op)
      3'd1: return rd;
      3'd2: return {{24{b[7]}}, b};
      3'd3: return {24'd0, b};
      3'd4: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      3'd6: return pc8;
      default: return alu;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] op, input logic [1:0] a);
    return (op == 3'd1 && a != 2'd0) || ((op == 3'd4 || op == 3'd5) && a[0]);
  endfunction

  function automatic logic [71:0] observed();
    return {wb_bus.jumpW, wb_bus.RegWriteW, wb_bus.WriteRegW, wb_bus.ResultW,
            wb_bus.MisalignW, wb_bus.RetireCountW};
  endfunction

  // driver: apply one cycle of inputs at the falling edge and push the expectation
  task automatic drive(input logic r, input logic s, input logic f, input logic j,
                       input logic rw, input logic [2:0] op, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] pc8, input logic [31:0] rd);
    logic m;
    @(negedge clk);
    rst = r;
    wb_bus.stallW = s;
    wb_bus.flushW = f;
    wb_bus.jumpM = j;
    wb_bus.RegWriteM = rw;
    wb_bus.MemtoRegM = op;
    wb_bus.WriteRegM = wr;
    wb_bus.ALUMultOutM = alu;
    wb_bus.PCPlus8M = pc8;
    wb_bus.ReadDataM = rd;
    m = model_mis(op, alu[1:0]);
    if (r) begin
      {m_jump, m_rw, m_wreg, m_res, m_mis} = '0;
      m_cnt = 32'd0;
    end else if (f) begin
      {m_jump, m_rw, m_wreg, m_res, m_mis} = '0;
    end else if (!s) begin
      m_jump = j;
      m_wreg = wr;
      m_res = model_sel(op, alu, pc8, rd);
      m_mis = m;
      m_rw = rw && (wr != 5'd0) && !m;
      if (m_rw) m_cnt = m_cnt + 32'd1;
    end
    exp_q.push_back({m_jump, m_rw, m_wreg, m_res, m_mis, m_cnt});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [71:0] got, exp;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 1, 1, 3'd1, 5'd9, 32'h1234_5670, 32'h44, 32'hFFFF_FFFF);
      step();
      got = observed(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %h exp %h", i, got, exp);
      end
    end
    vectors++;
    if (observed() !== 72'd0) begin
      miscompares++;
      $display("FAIL reset_zero: got %h exp 0", observed());
    end
  endtask

  task automatic test_lw();
    logic [71:0] got, exp;
    drive(0, 0, 0, 0, 1, 3'd1, 5'd8, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF);
    step();
    got = observed(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL lw: got %h exp %h", got, exp);
    end
    vectors++;
    if (wb_bus.ResultW !== 32'hDEAD_BEEF || wb_bus.RegWriteW !== 1'b1 ||
        wb_bus.WriteRegW !== 5'd8 || wb_bus.RetireCountW !== 32'd1) begin
      miscompares++;
      $display("FAIL lw_const: got res=%h we=%b rd=%0d cnt=%0d exp res=deadbeef we=1 rd=8 cnt=1",
               wb_bus.ResultW, wb_bus.RegWriteW, wb_bus.WriteRegW, wb_bus.RetireCountW);
    end
  endtask

  task automatic test_byte_loads();
    logic [71:0] got, exp;
    logic [2:0]  ops[5] = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
    logic [1:0]  offs[5] = '{2'd1, 2'd1, 2'd3, 2'd0, 2'd2};
    logic [31:0] want[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                             32'h0000_0012, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, ops[i], 5'd10 + 5'(i), 32'h2000_0000 | 32'(offs[i]), 32'h0, 32'h1280_FF7F);
      step();
      got = observed(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL byte[%0d]: got %h exp %h", i, got, exp);
      end
      vectors++;
      if (wb_bus.ResultW !== want[i]) begin
        miscompares++;
        $display("FAIL byte_val[%0d]: got %h exp %h", i, wb_bus.ResultW, want[i]);
      end
    end
  endtask

  task automatic test_half_loads();
    logic [71:0] got, exp;
    logic [31:0] cnt_before;
    logic [2:0]  ops[5] = '{3'd4, 3'd5, 3'd4, 3'd1, 3'd5};
    logic [1:0]  offs[5] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    logic        want_mis[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      cnt_before = m_cnt;
      drive(0, 0, 0, 0, 1, ops[i], 5'd20, 32'h3000_0000 | 32'(offs[i]), 32'h0, 32'h8001_ABCD);
      step();
      got = observed(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL half[%0d]: got %h exp %h", i, got, exp);
      end
      vectors++;
      if (wb_bus.MisalignW !== want_mis[i] || wb_bus.RegWriteW !== !want_mis[i] ||
          wb_bus.RetireCountW !== cnt_before + (want_mis[i] ? 32'd0 : 32'd1)) begin
        miscompares++;
        $display("FAIL half_mis[%0d]: got mis=%b we=%b cnt=%0d exp mis=%b", i,
                 wb_bus.MisalignW, wb_bus.RegWriteW, wb_bus.RetireCountW, want_mis[i]);
      end
    end
    vectors++;
    drive(0, 0, 0, 0, 1, 3'd4, 5'd20, 32'h3000_0002, 32'h0, 32'h8001_ABCD);
    step();
    void'(exp_q.pop_front());
    if (wb_bus.ResultW !== 32'hFFFF_ABCD) begin
      miscompares++;
      $display("FAIL lh_const: got %h exp ffffabcd", wb_bus.ResultW);
    end
  endtask

  task automatic test_link_r0();
    logic [71:0] got, exp;
    logic [4:0]  regs[4] = '{5'd31, 5'd0, 5'd7, 5'd0};
    logic [2:0]  ops[4] = '{3'd6, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, ops[i], regs[i], 32'hCAFE_0003, 32'h0040_0010, 32'h5555_5555);
      step();
      got = observed(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL link[%0d]: got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [71:0] got, exp;
    drive(0, 0, 0, 0, 1, 3'd6, 5'd5, 32'h0, 32'h0040_0010, 32'h0);
    step();
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, 3'($urandom_range(0, 7)), 5'($urandom_range(1, 31)),
            $urandom, $urandom, $urandom);
      step();
      got = observed(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %h exp %h", i, got, exp);
      end
      vectors++;
      if (wb_bus.ResultW !== 32'h0040_0010 || wb_bus.WriteRegW !== 5'd5) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got res=%h rd=%0d exp 00400010 rd=5", i,
                 wb_bus.ResultW, wb_bus.WriteRegW);
      end
    end
    drive(0, 1, 1, 1, 1, 3'd1, 5'd9, 32'h0, 32'h0, 32'h7777_7777);
    step();
    got = observed(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || wb_bus.RegWriteW !== 1'b0 || wb_bus.ResultW !== 32'd0) begin
      miscompares++;
      $display("FAIL stall_flush: got %h exp %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [71:0] got, exp;
    for (int i = 0; i < 60; i++) begin
      drive(0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
            1'($urandom), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom);
      step();
      got = observed(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %h exp %h", i, got, exp);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [71:0] got, exp;
    drive(0, 1, 0, 0, 1, 3'd0, 5'd3, 32'h0, 32'h0, 32'h0);
    step();
    void'(exp_q.pop_front());
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 32'hFFFF_FFFF;
    drive(0, 0, 0, 0, 1, 3'd1, 5'd4, 32'h0, 32'h0, 32'h0BAD_F00D);
    step();
    got = observed(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || wb_bus.RetireCountW !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap: got %h exp %h", got, exp);
    end
    drive(0, 0, 0, 0, 1, 3'd1, 5'd4, 32'h0, 32'h0, 32'h1111_2222);
    step();
    void'(exp_q.pop_front());
    drive(1, 0, 0, 1, 1, 3'd1, 5'd4, 32'h0, 32'h0, 32'h3333_4444);
    step();
    got = observed(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || got !== 72'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h exp %h", got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    wb_bus.stallW = 1'b0;
    wb_bus.flushW = 1'b0;
    wb_bus.jumpM = 1'b0;
    wb_bus.RegWriteM = 1'b0;
    wb_bus.MemtoRegM = 3'd0;
    wb_bus.WriteRegM = 5'd0;
    wb_bus.ALUMultOutM = 32'd0;
    wb_bus.PCPlus8M = 32'd0;
    wb_bus.ReadDataM = 32'd0;
    {m_jump, m_rw, m_wreg, m_res, m_mis, m_cnt} = '0;

    test_reset();
    test_lw();
    test_byte_loads();
    test_half_loads();
    test_link_r0();
    test_stall_flush();
    test_back_to_back();
    test_wrap_and_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
